m_ptw_dram_arb: RTL and testbench

M_PTW_DRAM_ARB -- requirements
Module: m_ptw_dram_arb

---
 rtl/m_ptw_dram_arb.sv | 169 ++++++++++++++++
 tb/tb_m_ptw_dram_arb.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_ptw_dram_arb.sv
// Single-port DRAM arbiter between the page-table walker and the CPU.
// One transaction in flight; page-walk preferred, with a starvation guard for the CPU.
module m_ptw_dram_arb #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        RST_X,

  input  logic        w_pw_req,
  input  logic        w_pw_we,
  input  logic [31:0] w_pw_addr,
  input  logic [31:0] w_pw_wdata,
  output logic        w_pw_done,
  output logic [31:0] w_pw_rdata,

  input  logic        w_cpu_req,
  input  logic        w_cpu_we,
  input  logic [31:0] w_cpu_addr,
  input  logic [31:0] w_cpu_wdata,
  output logic        w_cpu_done,
  output logic [31:0] w_cpu_rdata,

  output logic        w_dram_busy,
  output logic        w_dram_req,
  output logic        w_dram_we,
  output logic [31:0] w_dram_addr,
  output logic [31:0] w_dram_wdata,
  input  logic        w_dram_ack,
  input  logic        w_dram_rvalid,
  input  logic [31:0] w_dram_rdata
);

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef enum logic {
    G_PW  = 1'b0,
    G_CPU = 1'b1
  } grant_t;

  state_t        state_q,     state_d;
  grant_t        grant_q,     grant_d;
  logic          we_q,        we_d;
  logic [31:0]   addr_q,      addr_d;
  logic [31:0]   wdata_q,     wdata_d;
  logic [CW-1:0] starve_q,    starve_d;
  logic [31:0]   pw_rdata_q,  pw_rdata_d;
  logic [31:0]   cpu_rdata_q, cpu_rdata_d;

  logic cpu_wins;
  logic capture;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d      = state_q;
    grant_d      = grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    starve_d     = starve_q;
    pw_rdata_d   = pw_rdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    cpu_wins     = 1'b0;
    capture      = 1'b0;

    w_dram_busy  = (state_q != S_IDLE);
    w_dram_req   = 1'b0;
    w_dram_we    = 1'b0;
    w_dram_addr  = '0;
    w_dram_wdata = '0;
    w_pw_done    = 1'b0;
    w_cpu_done   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (w_pw_req || w_cpu_req) begin
          // CPU only overtakes a waiting page walk once it has been starved long enough.
          cpu_wins = w_cpu_req && (!w_pw_req || (starve_q == LIMIT));
          if (cpu_wins) begin
            grant_d  = G_CPU;
            we_d     = w_cpu_we;
            addr_d   = w_cpu_addr;
            wdata_d  = w_cpu_wdata;
            starve_d = '0;
          end else begin
            grant_d  = G_PW;
            we_d     = w_pw_we;
            addr_d   = w_pw_addr;
            wdata_d  = w_pw_wdata;
            if (!w_cpu_req)            starve_d = '0;
            else if (starve_q != LIMIT) starve_d = starve_q + 1'b1;
          end
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        w_dram_req   = 1'b1;
        w_dram_we    = we_q;
        w_dram_addr  = addr_q;
        w_dram_wdata = wdata_q;
        if (w_dram_ack) begin
          if (we_q) begin
            state_d = S_DONE;
          end else if (w_dram_rvalid) begin
            capture = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        if (w_dram_rvalid) begin
          capture = 1'b1;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        w_pw_done  = (grant_q == G_PW);
        w_cpu_done = (grant_q == G_CPU);
        state_d    = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    if (capture) begin
      if (grant_q == G_PW) pw_rdata_d  = w_dram_rdata;
      else                 cpu_rdata_d = w_dram_rdata;
    end
  end

  assign w_pw_rdata  = pw_rdata_q;
  assign w_cpu_rdata = cpu_rdata_q;

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!RST_X) begin
      state_q     <= S_IDLE;
      grant_q     <= G_PW;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      starve_q    <= '0;
      pw_rdata_q  <= '0;
      cpu_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      starve_q    <= starve_d;
      pw_rdata_q  <= pw_rdata_d;
      cpu_rdata_q <= cpu_rdata_d;
    end
  end

endmodule

// File: tb/tb_m_ptw_dram_arb.sv
// Bench for m_ptw_dram_arb: transaction-level model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_m_ptw_dram_arb;

  localparam int LIMIT = 4;

  logic        CLK = 1'b0;
  logic        RST_X;
  logic        w_pw_req, w_pw_we, w_cpu_req, w_cpu_we;
  logic [31:0] w_pw_addr, w_pw_wdata, w_cpu_addr, w_cpu_wdata;
  logic        w_dram_ack, w_dram_rvalid;
  logic [31:0] w_dram_rdata;
  logic        w_pw_done, w_cpu_done, w_dram_busy, w_dram_req, w_dram_we;
  logic [31:0] w_pw_rdata, w_cpu_rdata, w_dram_addr, w_dram_wdata;

  always #5 CLK = ~CLK;

  m_ptw_dram_arb #(.STARVE_LIMIT(LIMIT)) dut (
    .CLK(CLK), .RST_X(RST_X),
    .w_pw_req(w_pw_req), .w_pw_we(w_pw_we), .w_pw_addr(w_pw_addr), .w_pw_wdata(w_pw_wdata),
    .w_pw_done(w_pw_done), .w_pw_rdata(w_pw_rdata),
    .w_cpu_req(w_cpu_req), .w_cpu_we(w_cpu_we), .w_cpu_addr(w_cpu_addr), .w_cpu_wdata(w_cpu_wdata),
    .w_cpu_done(w_cpu_done), .w_cpu_rdata(w_cpu_rdata),
    .w_dram_busy(w_dram_busy), .w_dram_req(w_dram_req), .w_dram_we(w_dram_we),
    .w_dram_addr(w_dram_addr), .w_dram_wdata(w_dram_wdata),
    .w_dram_ack(w_dram_ack), .w_dram_rvalid(w_dram_rvalid), .w_dram_rdata(w_dram_rdata)
  );

  int checks = 0;
  int errors = 0;

  // Transaction-level model: the single in-flight request and its progress.
  bit          m_active, m_who, m_we, m_acked, m_fin;
  logic [31:0] m_addr, m_wdata;
  int          m_starve;
  logic [31:0] m_rd [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit cpu_first;
    if (!RST_X) begin
      m_active = 0; m_who = 0; m_we = 0; m_acked = 0; m_fin = 0;
      m_addr = 0; m_wdata = 0; m_starve = 0; m_rd[0] = 0; m_rd[1] = 0;
    end else if (!m_active) begin
      if (w_pw_req || w_cpu_req) begin
        cpu_first = w_cpu_req && (!w_pw_req || m_starve == LIMIT);
        if (cpu_first) begin
          m_who = 1; m_we = w_cpu_we; m_addr = w_cpu_addr; m_wdata = w_cpu_wdata;
          m_starve = 0;
        end else begin
          m_who = 0; m_we = w_pw_we; m_addr = w_pw_addr; m_wdata = w_pw_wdata;
          m_starve = w_cpu_req ? ((m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1) : 0;
        end
        m_active = 1; m_acked = 0; m_fin = 0;
      end
    end else if (m_fin) begin
      m_active = 0;
    end else if (!m_acked) begin
      if (w_dram_ack) begin
        m_acked = 1;
        if (m_we) m_fin = 1;
        else if (w_dram_rvalid) begin m_rd[m_who] = w_dram_rdata; m_fin = 1; end
      end
    end else if (w_dram_rvalid) begin
      m_rd[m_who] = w_dram_rdata; m_fin = 1;
    end
  endtask

  task automatic compare_all();
    bit exp_req;
    exp_req = m_active && !m_acked && !m_fin;
    check("busy", {31'd0, w_dram_busy}, {31'd0, m_active});
    check("dram_req", {31'd0, w_dram_req}, {31'd0, exp_req});
    if (exp_req) begin
      check("dram_we", {31'd0, w_dram_we}, {31'd0, m_we});
      check("dram_addr", w_dram_addr, m_addr);
      check("dram_wdata", w_dram_wdata, m_wdata);
    end
    check("pw_done", {31'd0, w_pw_done}, {31'd0, m_active && m_fin && !m_who});
    check("cpu_done", {31'd0, w_cpu_done}, {31'd0, m_active && m_fin && m_who});
    check("pw_rdata", w_pw_rdata, m_rd[0]);
    check("cpu_rdata", w_cpu_rdata, m_rd[1]);
    check("done_excl", {31'd0, w_pw_done & w_cpu_done}, 32'd0);
  endtask

  task automatic advance();
    model_step();
    @(posedge CLK);
    #1;
    compare_all();
  endtask

  initial begin
    int nd, nreq;
    logic [9:0] seq;
    bit pw_pend, cpu_pend;

    RST_X = 0;
    w_pw_req = 0; w_pw_we = 0; w_pw_addr = 0; w_pw_wdata = 0;
    w_cpu_req = 0; w_cpu_we = 0; w_cpu_addr = 0; w_cpu_wdata = 0;
    w_dram_ack = 0; w_dram_rvalid = 0; w_dram_rdata = 0;
    advance();
    advance();
    check("rst_busy", {31'd0, w_dram_busy}, 32'd0);
    check("rst_req", {31'd0, w_dram_req}, 32'd0);
    check("rst_pw_rdata", w_pw_rdata, 32'd0);
    check("rst_cpu_rdata", w_cpu_rdata, 32'd0);
    RST_X = 1;

    // Page-walk read, fastest path.
    w_pw_req = 1; w_pw_we = 0; w_pw_addr = 32'h0080_1004;
    advance();
    check("r19_issue", {31'd0, w_dram_req}, 32'd1);
    check("r19_addr", w_dram_addr, 32'h0080_1004);
    check("r19_early_done", {31'd0, w_pw_done}, 32'd0);
    w_dram_ack = 1; w_dram_rvalid = 1; w_dram_rdata = 32'h2000_0C01;
    advance();
    check("r19_done", {31'd0, w_pw_done}, 32'd1);
    check("r19_rdata", w_pw_rdata, 32'h2000_0C01);
    w_pw_req = 0; w_dram_ack = 0; w_dram_rvalid = 0;
    advance();
    check("r19_done_once", {31'd0, w_pw_done}, 32'd0);

    // Page-walk write with ack held off for five cycles.
    w_pw_req = 1; w_pw_we = 1; w_pw_wdata = 32'h2000_0CC1;
    advance();
    nreq = 0;
    for (int i = 0; i < 6; i++) begin
      check("r21_req", {31'd0, w_dram_req}, 32'd1);
      check("r21_addr", w_dram_addr, 32'h0080_1004);
      check("r21_wdata", w_dram_wdata, 32'h2000_0CC1);
      check("r21_no_done", {31'd0, w_pw_done}, 32'd0);
      nreq += int'(w_dram_req);
      w_dram_ack = (i == 5); w_dram_rvalid = (i == 5); w_dram_rdata = 32'hDEAD_BEEF;
      advance();
    end
    check("r21_req_cycles", nreq, 6);
    check("r21_done", {31'd0, w_pw_done}, 32'd1);
    w_pw_req = 0; w_dram_ack = 0; w_dram_rvalid = 0;
    advance();
    check("r21_done_once", {31'd0, w_pw_done}, 32'd0);
    check("r21_rdata_kept", w_pw_rdata, 32'h2000_0C01);

    // CPU read, rvalid four cycles after ack.
    w_cpu_req = 1; w_cpu_we = 0; w_cpu_addr = 32'h1000_0040;
    advance();
    w_dram_ack = 1;
    advance();
    w_dram_ack = 0;
    for (int i = 0; i < 4; i++) begin
      check("r22_busy", {31'd0, w_dram_busy}, 32'd1);
      check("r22_req_low", {31'd0, w_dram_req}, 32'd0);
      check("r22_no_done", {31'd0, w_cpu_done}, 32'd0);
      w_dram_rvalid = (i == 3); w_dram_rdata = 32'hCAFE_0022;
      advance();
    end
    check("r22_done", {31'd0, w_cpu_done}, 32'd1);
    check("r22_busy_done", {31'd0, w_dram_busy}, 32'd1);
    check("r22_rdata", w_cpu_rdata, 32'hCAFE_0022);
    w_cpu_req = 0; w_dram_rvalid = 0;
    advance();
    check("r22_idle", {31'd0, w_dram_busy}, 32'd0);

    // Both requesting continuously: four page walks, then the CPU.
    w_pw_req = 1; w_pw_we = 0; w_cpu_req = 1; w_cpu_we = 0;
    nd = 0; seq = '0;
    for (int c = 0; c < 200 && nd < 10; c++) begin
      w_dram_ack = w_dram_req; w_dram_rvalid = w_dram_req; w_dram_rdata = $urandom;
      advance();
      if (w_pw_done || w_cpu_done) begin
        seq[nd] = w_cpu_done;
        nd++;
      end
    end
    check("r20_count", nd, 10);
    check("r20_order", {22'd0, seq}, 32'b10_0001_0000);
    w_pw_req = 0; w_cpu_req = 0; w_dram_ack = 0; w_dram_rvalid = 0;
    advance();

    // Reset while waiting for read data.
    w_cpu_req = 1; w_cpu_addr = 32'h1000_0080;
    advance();
    w_dram_ack = 1;
    advance();
    w_dram_ack = 0;
    advance();
    RST_X = 0;
    advance();
    check("r23_busy", {31'd0, w_dram_busy}, 32'd0);
    check("r23_req", {31'd0, w_dram_req}, 32'd0);
    check("r23_we", {31'd0, w_dram_we}, 32'd0);
    check("r23_addr", w_dram_addr, 32'd0);
    check("r23_wdata", w_dram_wdata, 32'd0);
    check("r23_dones", {30'd0, w_pw_done, w_cpu_done}, 32'd0);
    check("r23_pw_rdata", w_pw_rdata, 32'd0);
    check("r23_cpu_rdata", w_cpu_rdata, 32'd0);
    w_cpu_req = 0; RST_X = 1;
    nd = 0;
    for (int i = 0; i < 6; i++) begin
      w_dram_rvalid = (i == 1); w_dram_rdata = 32'h5555_AAAA;
      advance();
      nd += int'(w_pw_done) + int'(w_cpu_done);
    end
    check("r23_no_done", nd, 0);
    check("r23_stray_ignored", w_cpu_rdata, 32'd0);
    w_pw_req = 1; w_pw_we = 0; w_pw_addr = 32'h0080_2000; w_dram_rvalid = 0;
    advance();
    w_dram_ack = 1; w_dram_rvalid = 1; w_dram_rdata = 32'h1234_5678;
    advance();
    check("r23_after_done", {31'd0, w_pw_done}, 32'd1);
    check("r23_after_rdata", w_pw_rdata, 32'h1234_5678);
    w_pw_req = 0; w_dram_ack = 0; w_dram_rvalid = 0;
    advance();

    // Randomized traffic, stray rvalids, mid-flight drops and occasional resets.
    pw_pend = 0; cpu_pend = 0;
    for (int c = 0; c < 4000; c++) begin
      if (m_active && m_fin && !m_who) begin
        pw_pend = ($urandom_range(0, 1) == 1);
        w_pw_we = $urandom_range(0, 1); w_pw_addr = $urandom; w_pw_wdata = $urandom;
      end else if (!pw_pend && !(m_active && !m_who)) begin
        if ($urandom_range(0, 2) == 0) begin
          pw_pend = 1;
          w_pw_we = $urandom_range(0, 1); w_pw_addr = $urandom; w_pw_wdata = $urandom;
        end
      end else if (pw_pend && m_active && !m_who && $urandom_range(0, 15) == 0) begin
        pw_pend = 0;
      end

      if (m_active && m_fin && m_who) begin
        cpu_pend = ($urandom_range(0, 1) == 1);
        w_cpu_we = $urandom_range(0, 1); w_cpu_addr = $urandom; w_cpu_wdata = $urandom;
      end else if (!cpu_pend && !(m_active && m_who)) begin
        if ($urandom_range(0, 2) == 0) begin
          cpu_pend = 1;
          w_cpu_we = $urandom_range(0, 1); w_cpu_addr = $urandom; w_cpu_wdata = $urandom;
        end
      end else if (cpu_pend && m_active && m_who && $urandom_range(0, 15) == 0) begin
        cpu_pend = 0;
      end

      RST_X = 1;
      if ($urandom_range(0, 149) == 0) begin
        RST_X = 0; pw_pend = 0; cpu_pend = 0;
      end

      w_pw_req      = pw_pend;
      w_cpu_req     = cpu_pend;
      w_dram_ack    = (m_active && !m_acked && !m_fin) && ($urandom_range(0, 1) == 1);
      w_dram_rvalid = ($urandom_range(0, 3) == 0);
      w_dram_rdata  = $urandom;
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
